// File: rtl/hub75_pkg.sv
// Shared widths, blank default and swap-state encoding
// for the HUB75 double-buffered frame store.
package hub75_pkg;

  localparam logic [63:0] BLANK_ALL = '1;

  function automatic int read_aw(int w, int rows);
    return $clog2(rows / 2) + $clog2(w);
  endfunction

  function automatic int write_aw(int w, int rows);
    return $clog2(rows) + $clog2(w);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } swap_state_t;

endpackage

// File: rtl/hub75_frame_buffer_if.sv
// Writer / scanner / swap bus of the HUB75 frame store.
// Clear signals exist only with HUB75_FB_CLEAR_EN.
interface hub75_frame_buffer_if #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int PANEL_WIDTH    = 64,
  parameter int PANEL_ROWS     = 32
);
  import hub75_pkg::*;

  localparam int WA = write_aw(PANEL_WIDTH, PANEL_ROWS);
  localparam int RA = read_aw(PANEL_WIDTH, PANEL_ROWS);

  logic [WA-1:0]             write_addr;
  logic [BITS_PER_PIXEL-1:0] write_data;
  logic                      write_en;
  logic [RA-1:0]             read_addr;
  logic                      read_en;
  logic [BITS_PER_PIXEL-1:0] read_data_top;
  logic [BITS_PER_PIXEL-1:0] read_data_bottom;
  logic                      read_valid;
  logic                      frame_done;
  logic                      swap_req;
  logic                      swap_pending;
  logic                      swap_ack;
  logic                      front_sel;
  logic                      write_dropped;
`ifdef HUB75_FB_CLEAR_EN
  logic                      clear_start;
  logic [BITS_PER_PIXEL-1:0] clear_value;
  logic                      clear_busy;
`endif

  modport master (
    output write_addr, write_data, write_en,
    output read_addr, read_en, frame_done, swap_req,
    input  read_data_top, read_data_bottom, read_valid,
    input  swap_pending, swap_ack, front_sel, write_dropped
`ifdef HUB75_FB_CLEAR_EN
    , output clear_start, clear_value
    , input  clear_busy
`endif
  );

  modport slave (
    input  write_addr, write_data, write_en,
    input  read_addr, read_en, frame_done, swap_req,
    output read_data_top, read_data_bottom, read_valid,
    output swap_pending, swap_ack, front_sel, write_dropped
`ifdef HUB75_FB_CLEAR_EN
    , input  clear_start, clear_value
    , output clear_busy
`endif
  );

endinterface

// File: rtl/hub75_fb_bank.sv
// One half-panel RAM holding both buffers; addr MSB = buffer.
// Ports: write (we/waddr/wdata), registered read (re/raddr/rdata).
module hub75_fb_bank #(
  parameter int DW = 24,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hub75_frame_buffer.sv
// HUB75 double-buffered frame store, tear-free swap at frame end.
// Ports: clk, reset_n (sync, low), bus (slave). Clear: HUB75_FB_CLEAR_EN.
module hub75_frame_buffer
  import hub75_pkg::*;
#(
  parameter int BITS_PER_PIXEL = 24,
  parameter int PANEL_WIDTH    = 64,
  parameter int PANEL_ROWS     = 32,
  parameter logic [BITS_PER_PIXEL-1:0] BLANK_VALUE =
    BLANK_ALL[BITS_PER_PIXEL-1:0]
) (
  input  logic clk,
  input  logic reset_n,
  hub75_frame_buffer_if.slave bus
);

  localparam int RA = read_aw(PANEL_WIDTH, PANEL_ROWS);
  localparam int WA = RA + 1;
  localparam int DW = BITS_PER_PIXEL;

  swap_state_t   state;
  logic          front_sel;
  logic          swap_pending;
  logic          swap_ack;
  logic          read_valid;
  logic          busy;
  logic [RA-1:0] clr_cnt;
  logic [DW-1:0] clr_val;
  logic          top_we;
  logic          bot_we;
  logic [RA:0]   bank_waddr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] q_top;
  logic [DW-1:0] q_bot;
  logic          half;
  logic          commit_ok;

  assign half      = bus.write_addr[WA-1];
  assign commit_ok = bus.frame_done & ~busy;

`ifdef HUB75_FB_CLEAR_EN
  logic dropped;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      clr_cnt <= '0;
      clr_val <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= busy & bus.write_en;
      if (busy) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (&clr_cnt) busy <= 1'b0;
      end else if (bus.clear_start) begin
        busy    <= 1'b1;
        clr_cnt <= '0;
        clr_val <= bus.clear_value;
      end
    end
  end

  assign bus.clear_busy    = busy;
  assign bus.write_dropped = dropped;
`else
  assign busy              = 1'b0;
  assign clr_cnt           = '0;
  assign clr_val           = '0;
  assign bus.write_dropped = 1'b0;
`endif

  // The clear engine owns the write port while busy.
  always_comb begin
    top_we     = bus.write_en & ~half;
    bot_we     = bus.write_en & half;
    bank_waddr = {~front_sel, bus.write_addr[RA-1:0]};
    bank_wdata = bus.write_data;
    if (busy) begin
      top_we     = 1'b1;
      bot_we     = 1'b1;
      bank_waddr = {~front_sel, clr_cnt};
      bank_wdata = clr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      unique case (state)
        IDLE, COMMIT: begin
          state <= IDLE;
          if (bus.swap_req) begin
            if (commit_ok) begin
              state     <= COMMIT;
              front_sel <= ~front_sel;
              swap_ack  <= 1'b1;
            end else begin
              state        <= PENDING;
              swap_pending <= 1'b1;
            end
          end
        end
        PENDING: begin
          if (commit_ok) begin
            state        <= COMMIT;
            front_sel    <= ~front_sel;
            swap_ack     <= 1'b1;
            swap_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) read_valid <= 1'b0;
    else          read_valid <= bus.read_en;
  end

  hub75_fb_bank #(.DW(DW), .AW(RA + 1)) u_top (
    .clk   (clk),
    .we    (top_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (bus.read_en),
    .raddr ({front_sel, bus.read_addr}),
    .rdata (q_top)
  );

  hub75_fb_bank #(.DW(DW), .AW(RA + 1)) u_bot (
    .clk   (clk),
    .we    (bot_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .re    (bus.read_en),
    .raddr ({front_sel, bus.read_addr}),
    .rdata (q_bot)
  );

  assign bus.read_data_top    = read_valid ? q_top : BLANK_VALUE;
  assign bus.read_data_bottom = read_valid ? q_bot : BLANK_VALUE;
  assign bus.read_valid       = read_valid;
  assign bus.swap_pending     = swap_pending;
  assign bus.swap_ack         = swap_ack;
  assign bus.front_sel        = front_sel;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Randomized scoreboard bench for hub75_frame_buffer.
// Model keeps both buffers as [buf][physical row][col] arrays.
module tb_hub75_frame_buffer;

  localparam int W    = 64;
  localparam int ROWS = 32;
  localparam int HR   = ROWS / 2;
  localparam logic [23:0] BLANK = 24'hFFFFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hub75_frame_buffer_if #(
    .BITS_PER_PIXEL(24), .PANEL_WIDTH(W), .PANEL_ROWS(ROWS)
  ) bus ();

  hub75_frame_buffer #(
    .BITS_PER_PIXEL(24), .PANEL_WIDTH(W), .PANEL_ROWS(ROWS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [2][ROWS][W];
  int   m_front = 0;
  bit   m_pend, m_ack, m_rv, m_drop;
  int   clr_left = 0;
  logic [23:0] clr_val;
  logic [47:0] exp_q [$];
  bit   mon_en = 1'b0;

`ifdef HUB75_FB_CLEAR_EN
  logic        cs_d = 1'b0;
  logic [23:0] cv_d = '0;
`endif

  task automatic chk(input string name, input logic [47:0] act,
                     input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [47:0] e;
      chk("read_valid", 48'(bus.read_valid), 48'(m_rv));
      if (bus.read_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 48'(1), 48'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rd_top", 48'(bus.read_data_top), 48'(e[47:24]));
          chk("rd_bottom", 48'(bus.read_data_bottom), 48'(e[23:0]));
        end
      end else begin
        chk("blank_top", 48'(bus.read_data_top), 48'(BLANK));
        chk("blank_bottom", 48'(bus.read_data_bottom), 48'(BLANK));
      end
      chk("front_sel", 48'(bus.front_sel), 48'(m_front));
      chk("swap_pending", 48'(bus.swap_pending), 48'(m_pend));
      chk("swap_ack", 48'(bus.swap_ack), 48'(m_ack));
      chk("write_dropped", 48'(bus.write_dropped), 48'(m_drop));
`ifdef HUB75_FB_CLEAR_EN
      chk("clear_busy", 48'(bus.clear_busy), 48'(clr_left > 0));
`endif
    end
  end

  task automatic model_reset();
    m_front  = 0;
    m_pend   = 1'b0;
    m_ack    = 1'b0;
    m_rv     = 1'b0;
    m_drop   = 1'b0;
    clr_left = 0;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_reset();
      @(negedge clk);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic step(input bit we, input logic [10:0] wa,
                      input logic [23:0] wd, input bit re,
                      input logic [9:0] ra, input bit sr, input bit fd);
    bit busy_now;
    int r, c;
    bus.write_en   = we;
    bus.write_addr = wa;
    bus.write_data = wd;
    bus.read_en    = re;
    bus.read_addr  = ra;
    bus.swap_req   = sr;
    bus.frame_done = fd;
`ifdef HUB75_FB_CLEAR_EN
    bus.clear_start = cs_d;
    bus.clear_value = cv_d;
`endif
    @(posedge clk);
    busy_now = clr_left > 0;
    m_rv = re;
    if (re) begin
      r = int'(ra[9:6]);
      c = int'(ra[5:0]);
      exp_q.push_back({mem[m_front][r][c], mem[m_front][r + HR][c]});
    end
    m_drop = we && busy_now;
    if (we && !busy_now)
      mem[1 - m_front][int'(wa[10:6])][int'(wa[5:0])] = wd;
    m_ack = 1'b0;
    if ((m_pend || sr) && fd && !busy_now) begin
      m_front = 1 - m_front;
      m_ack   = 1'b1;
      m_pend  = 1'b0;
    end else if (sr) begin
      m_pend = 1'b1;
    end
`ifdef HUB75_FB_CLEAR_EN
    if (busy_now) begin
      clr_left--;
      if (clr_left == 0)
        for (int y = 0; y < ROWS; y++)
          for (int x = 0; x < W; x++)
            mem[1 - m_front][y][x] = clr_val;
    end else if (cs_d) begin
      clr_left = HR * W;
      clr_val  = cv_d;
    end
    cs_d = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    int acks;
    int f0;
    bus.write_en   = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.read_en    = 1'b0;
    bus.read_addr  = '0;
    bus.swap_req   = 1'b0;
    bus.frame_done = 1'b0;
`ifdef HUB75_FB_CLEAR_EN
    bus.clear_start = 1'b0;
    bus.clear_value = '0;
`endif
    @(negedge clk);
    do_reset(3);
    chk("reset_top", 48'(bus.read_data_top), 48'(BLANK));
    chk("reset_valid", 48'(bus.read_valid), 48'(0));
    chk("reset_front", 48'(bus.front_sel), 48'(0));
    chk("reset_pending", 48'(bus.swap_pending), 48'(0));

    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 2 * HR * W; a++)
        step(1, 11'(a), 24'($urandom), 0, '0, 0, 0);
      step(0, '0, '0, 0, '0, 1, 1);
    end

    step(1, 11'h005, 24'h112233, 0, '0, 0, 0);
    step(1, 11'h405, 24'h445566, 0, '0, 0, 0);
    step(0, '0, '0, 0, '0, 1, 0);
    step(0, '0, '0, 0, '0, 0, 1);
    step(0, '0, '0, 1, 10'h005, 0, 0);
    chk("a_top", 48'(bus.read_data_top), 48'h112233);
    chk("a_bottom", 48'(bus.read_data_bottom), 48'h445566);
    chk("a_valid", 48'(bus.read_valid), 48'(1));

    step(0, '0, '0, 0, '0, 1, 0);
    step(1, 11'h005, 24'hAABBCC, 0, '0, 0, 0);
    step(0, '0, '0, 1, 10'h005, 0, 0);
    chk("b_old_front", 48'(bus.read_data_top), 48'h112233);
    step(0, '0, '0, 0, '0, 0, 1);
    step(0, '0, '0, 1, 10'h005, 0, 0);
    chk("b_new_front", 48'(bus.read_data_top), 48'hAABBCC);

    f0 = int'(bus.front_sel);
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, '0, '0, 0, '0, i < 3, i == 3 || i == 5);
      if (bus.swap_ack) acks++;
    end
    chk("c_one_ack", 48'(acks), 48'(1));
    chk("c_toggled", 48'(bus.front_sel), 48'(f0 ^ 1));

    step(0, '0, '0, 1, 10'h005, 1, 1);
    chk("d_ack", 48'(bus.swap_ack), 48'(1));
    chk("d_front", 48'(bus.front_sel), 48'(f0));
    chk("d_old_data", 48'(bus.read_data_top), 48'h112233);

    step(0, '0, '0, 0, '0, 1, 0);
    step(1, 11'h005, 24'h778899, 0, '0, 0, 1);
    step(0, '0, '0, 1, 10'h005, 0, 0);
    chk("e_commit_write", 48'(bus.read_data_top), 48'h778899);

`ifdef HUB75_FB_CLEAR_EN
    step(0, '0, '0, 0, '0, 1, 0);
    cs_d = 1'b1;
    cv_d = 24'h000000;
    idle();
    acks = 0;
    for (int i = 0; i < HR * W; i++) begin
      step($urandom % 2, 11'($urandom), 24'($urandom),
           $urandom % 2, 10'($urandom), 0, i % 100 == 7);
      if (bus.swap_ack) acks++;
    end
    chk("clr_no_swap", 48'(acks), 48'(0));
    step(0, '0, '0, 0, '0, 0, 1);
    chk("clr_swap", 48'(bus.swap_ack), 48'(1));
    for (int a = 0; a < HR * W; a++)
      step(0, '0, '0, 1, 10'(a), 0, 0);
`endif

    for (int i = 0; i < 3000; i++)
      step($urandom % 2, 11'($urandom), 24'($urandom),
           $urandom % 2, 10'($urandom),
           $urandom % 8 == 0, $urandom % 16 == 0);

    step(0, '0, '0, 0, '0, 1, 0);
    do_reset(2);
    chk("rst_front", 48'(bus.front_sel), 48'(0));
    chk("rst_pending", 48'(bus.swap_pending), 48'(0));
    step(0, '0, '0, 0, '0, 0, 1);
    for (int i = 0; i < 40; i++)
      step(0, '0, '0, 1, 10'($urandom), 0, 0);

    idle();
    idle();
    chk("queue_empty", 48'(exp_q.size()), 48'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
